// File: rtl/pitch_sweep_multi.sv
// Multi-channel pitch-envelope generator: each lane sweeps its offset 0->LIMIT (fall)
// or LIMIT->0 (rise) at a per-lane exponential rate, restarted by note triggers.

module pitch_sweep_lane #(
    parameter int OUT_W  = 13,
    parameter int ACC_W  = 26,
    parameter int LIMIT  = 7680,
    parameter int THRESH = 8191
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    input  logic             note_on,
    input  logic             note_repeat,
    input  logic [6:0]       note,
    input  logic [3:0]       speed,
    input  logic             rise,
    output logic [OUT_W-1:0] amount,
    output logic             active,
    output logic             done
);
    typedef enum logic [1:0] {IDLE, RUN, HOLD} state_e;

    localparam logic [OUT_W-1:0] LIM = OUT_W'(LIMIT);
    localparam logic [ACC_W-1:0] THR = ACC_W'(THRESH);
    localparam logic [ACC_W-1:0] ONE = ACC_W'(1);

    state_e             state_q, state_d;
    logic [ACC_W-1:0]   timer_q, timer_d;
    logic [OUT_W-1:0]   amount_q, amount_d;
    logic [6:0]         note_q, note_d;
    logic               dir_q, dir_d;
    logic               on_q, on_d;
    logic               active_q, active_d;
    logic               done_q, done_d;

    logic               trig;
    logic [OUT_W-1:0]   end_val;
    logic [OUT_W-1:0]   next_amt;

    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q;
        amount_d = amount_q;
        note_d   = note_q;
        dir_d    = dir_q;
        on_d     = on_q;
        active_d = active_q;
        done_d   = 1'b0;
        trig     = note_on && (!on_q || (note != note_q) || note_repeat);
        end_val  = dir_q ? '0 : LIM;
        next_amt = dir_q ? amount_q - 1'b1 : amount_q + 1'b1;

        if (en) begin
            on_d = note_on;
            if (!note_on) begin
                state_d  = IDLE;
                active_d = 1'b0;
            end else if (trig) begin
                state_d  = RUN;
                timer_d  = ONE;
                note_d   = note;
                dir_d    = rise;
                amount_d = rise ? LIM : '0;
                active_d = 1'b1;
            end else if (state_q == RUN) begin
                if (amount_q == end_val) begin
                    // Degenerate start-at-end sweep: finish without overshooting.
                    state_d  = HOLD;
                    active_d = 1'b0;
                    done_d   = 1'b1;
                end else if (timer_q > THR) begin
                    timer_d  = ONE;
                    amount_d = next_amt;
                    if (next_amt == end_val) begin
                        state_d  = HOLD;
                        active_d = 1'b0;
                        done_d   = 1'b1;
                    end
                end else begin
                    timer_d = timer_q + (ONE << speed);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            timer_q  <= ONE;
            amount_q <= '0;
            note_q   <= '0;
            dir_q    <= 1'b0;
            on_q     <= 1'b0;
            active_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            amount_q <= amount_d;
            note_q   <= note_d;
            dir_q    <= dir_d;
            on_q     <= on_d;
            active_q <= active_d;
            done_q   <= done_d;
        end
    end

    assign amount = amount_q;
    assign active = active_q;
    assign done   = done_q;
endmodule

module pitch_sweep_multi #(
    parameter int CHANNELS = 4,
    parameter int OUT_W    = 13,
    parameter int ACC_W    = 26,
    parameter int LIMIT    = 7680,
    parameter int THRESH   = 8191
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      en,
    input  logic [CHANNELS-1:0]       note_on,
    input  logic [CHANNELS-1:0]       note_repeat,
    input  logic [7*CHANNELS-1:0]     note,
    input  logic [4*CHANNELS-1:0]     speed,
    input  logic [CHANNELS-1:0]       rise,
    output logic [OUT_W*CHANNELS-1:0] amount,
    output logic [CHANNELS-1:0]       active,
    output logic [CHANNELS-1:0]       done
);
    logic [CHANNELS-1:0][OUT_W-1:0] amount_a;

    for (genvar g = 0; g < CHANNELS; g++) begin : g_lane
        pitch_sweep_lane #(
            .OUT_W (OUT_W),
            .ACC_W (ACC_W),
            .LIMIT (LIMIT),
            .THRESH(THRESH)
        ) u_lane (
            .clk        (clk),
            .reset_n    (reset_n),
            .en         (en),
            .note_on    (note_on[g]),
            .note_repeat(note_repeat[g]),
            .note       (note[7*g +: 7]),
            .speed      (speed[4*g +: 4]),
            .rise       (rise[g]),
            .amount     (amount_a[g]),
            .active     (active[g]),
            .done       (done[g])
        );
    end

    assign amount = amount_a;
endmodule

// File: tb/tb_pitch_sweep_multi.sv
// Directed bench for pitch_sweep_multi with LIMIT=4: table-driven ch0 sweeps plus
// hand-written en-gating, reset and multi-channel sequences.

module tb_pitch_sweep_multi;
    localparam int CH    = 4;
    localparam int OUT_W = 13;

    logic                  clk = 1'b0;
    logic                  reset_n;
    logic                  en;
    logic [CH-1:0]         note_on, note_repeat, rise;
    logic [7*CH-1:0]       note;
    logic [4*CH-1:0]       speed;
    logic [OUT_W*CH-1:0]   amount;
    logic [CH-1:0]         active, done;

    int errors = 0;
    int checks = 0;

    pitch_sweep_multi #(
        .CHANNELS(CH), .OUT_W(OUT_W), .ACC_W(26), .LIMIT(4), .THRESH(8191)
    ) dut (
        .clk(clk), .reset_n(reset_n), .en(en), .note_on(note_on),
        .note_repeat(note_repeat), .note(note), .speed(speed), .rise(rise),
        .amount(amount), .active(active), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       on;
        logic [6:0] nt;
        logic       rs;
        logic       rep;
        int         amt;
        logic       act;
        logic       dn;
    } vec_t;

    vec_t tv[$];

    task automatic add(input logic on, input int nt, input logic rs, input logic rep,
                       input int amt, input logic act, input logic dn);
        vec_t v;
        v.on = on; v.nt = 7'(nt); v.rs = rs; v.rep = rep;
        v.amt = amt; v.act = act; v.dn = dn;
        tv.push_back(v);
    endtask

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    function automatic int amt_of(input int ch);
        return int'(amount[ch*OUT_W +: OUT_W]);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_n = 1'b0; en = 1'b1;
        note_on = '0; note_repeat = '0; rise = '0; note = '0;
        speed = {4'd13, 4'd13, 4'd13, 4'd13};
        #1;
        for (int c = 0; c < CH; c++) chk($sformatf("reset_amount%0d", c), amt_of(c), 0);
        chk("reset_active", int'(active), 0);
        chk("reset_done", int'(done), 0);
        tick();
        reset_n = 1'b1;
        tick();

        // fall sweep 0->4, HOLD, gate-off
        add(1,60,0,0, 0,1,0); add(1,60,0,0, 0,1,0);
        add(1,60,0,0, 1,1,0); add(1,60,0,0, 1,1,0);
        add(1,60,0,0, 2,1,0); add(1,60,0,0, 2,1,0);
        add(1,60,0,0, 3,1,0); add(1,60,0,0, 3,1,0);
        add(1,60,0,0, 4,0,1); add(1,60,0,0, 4,0,0);
        add(1,60,0,0, 4,0,0); add(0,60,0,0, 4,0,0);
        // rise sweep 4->0
        add(1,60,1,0, 4,1,0); add(1,60,1,0, 4,1,0);
        add(1,60,1,0, 3,1,0); add(1,60,1,0, 3,1,0);
        add(1,60,1,0, 2,1,0); add(1,60,1,0, 2,1,0);
        add(1,60,1,0, 1,1,0); add(1,60,1,0, 1,1,0);
        add(1,60,1,0, 0,0,1); add(1,60,1,0, 0,0,0);
        add(0,60,0,0, 0,0,0);
        // note change at amount 2, then note_repeat at amount 2
        add(1,60,0,0, 0,1,0); add(1,60,0,0, 0,1,0);
        add(1,60,0,0, 1,1,0); add(1,60,0,0, 1,1,0);
        add(1,60,0,0, 2,1,0); add(1,62,0,0, 0,1,0);
        add(1,62,0,0, 0,1,0); add(1,62,0,0, 1,1,0);
        add(1,62,0,0, 1,1,0); add(1,62,0,0, 2,1,0);
        add(1,62,0,1, 0,1,0); add(1,62,0,0, 0,1,0);
        add(1,62,0,0, 1,1,0); add(1,62,0,0, 1,1,0);
        add(1,62,0,0, 2,1,0); add(1,62,0,0, 2,1,0);
        add(1,62,0,0, 3,1,0);
        // gate-off at 3 holds, then note 0 restarts
        add(0,62,0,0, 3,0,0); add(0,62,0,0, 3,0,0);
        add(0,62,0,0, 3,0,0); add(1,0,0,0, 0,1,0);
        add(1,0,0,0, 0,1,0);  add(1,0,0,0, 1,1,0);

        foreach (tv[i]) begin
            note_on[0] = tv[i].on; note[6:0] = tv[i].nt;
            rise[0] = tv[i].rs; note_repeat[0] = tv[i].rep;
            tick();
            chk($sformatf("vec%0d_amount", i), amt_of(0), tv[i].amt);
            chk($sformatf("vec%0d_active", i), int'(active[0]), int'(tv[i].act));
            chk($sformatf("vec%0d_done", i), int'(done[0]), int'(tv[i].dn));
        end

        // en high 1 cycle in 4: two enabled cycles per step, done one clk wide
        note_on[0] = 1'b0; note_repeat[0] = 1'b0; rise[0] = 1'b0; note[6:0] = 7'd60;
        tick();
        note_on[0] = 1'b1;
        begin
            int n;
            int exp_amt;
            n = 0;
            for (int c = 0; c < 40; c++) begin
                en = (c % 4 == 0);
                tick();
                if (en) n++;
                exp_amt = (n - 1) / 2;
                if (exp_amt > 4) exp_amt = 4;
                chk($sformatf("engate%0d_amount", c), amt_of(0), exp_amt);
                chk($sformatf("engate%0d_done", c), int'(done[0]), int'(en && n == 9));
                chk($sformatf("engate%0d_active", c), int'(active[0]), int'(n < 9));
            end
        end
        en = 1'b1;

        // async reset in the middle of a sweep
        note_on[0] = 1'b0;
        tick();
        note_on[0] = 1'b1;
        tick();
        tick();
        tick();
        chk("prereset_amount", amt_of(0), 1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("midreset_amount", int'(amount), 0);
        chk("midreset_active", int'(active), 0);
        chk("midreset_done", int'(done), 0);
        note_on = '0;
        tick();
        reset_n = 1'b1;
        tick();
        chk("postreset_amount", amt_of(0), 0);

        // simultaneous triggers: ch0 speed 15, ch3 speed 0
        speed = {4'd0, 4'd13, 4'd13, 4'd15};
        note[27:21] = 7'd64;
        note_on = 4'b1001;
        tick();
        chk("multi_trig_active", int'(active), 9);
        for (int k = 1; k <= 8192; k++) begin
            tick();
            if (k <= 10) begin
                chk($sformatf("multi_ch0_k%0d", k), amt_of(0), (k / 2 > 4) ? 4 : k / 2);
                chk($sformatf("multi_ch0done_k%0d", k), int'(done[0]), int'(k == 8));
            end
            if (k == 1) chk("multi_ch1_idle", int'(active[2:1]), 0);
            if (k == 8191) begin
                chk("multi_ch3_amount_8191", amt_of(3), 0);
                chk("multi_ch3_active_8191", int'(active[3]), 1);
            end
            if (k == 8192) chk("multi_ch3_amount_8192", amt_of(3), 1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/pitch_sweep_multi.md
# pitch_sweep_multi

Multi-channel, parametrised pitch-envelope generator for the MIDI synth cores. Each channel produces a monotonic pitch offset that starts on a note trigger and advances at a per-channel programmable rate. Each channel sweeps either downward ("fall") or upward ("rise") toward a configurable limit. The offsets feed the per-voice frequency adders. One instance serves all voices of a sound chip.

## Interface
- CHANNELS, 4, number of independent voices
- OUT_W, 13, width of each offset output
- ACC_W, 26, width of each rate accumulator; must be ≥ 17
- LIMIT, 7680, sweep end value; must fit in OUT_W
- THRESH, 8191, accumulator threshold for one offset step

- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- en  in  1  global clock enable; all state frozen while low
- note_on  in  CHANNELS  per-channel gate
- note_repeat  in  CHANNELS  per-channel retrigger strobe for same-note re-strikes
- note  in  7*CHANNELS  per-channel MIDI note; channel i uses bits [7i+6:7i]
- speed  in  4*CHANNELS  per-channel rate exponent; channel i uses bits [4i+3:4i]
- rise  in  CHANNELS  per-channel direction, sampled at trigger: 0 = fall (0→LIMIT), 1 = rise (LIMIT→0)
- amount  out  OUT_W*CHANNELS  per-channel offset
- active  out  CHANNELS  high while the channel is in RUN
- done  out  CHANNELS  one-cycle pulse when the sweep reaches its end value

## Operation
- Each channel has independent state: an FSM, an ACC_W-bit timer, an OUT_W-bit amount, a latched note (note_q), a latched direction (dir_q), and a previous gate (on_q).
- FSM states are IDLE, RUN and HOLD.
- Trigger on an en cycle: `note_on & (!on_q | note != note_q | note_repeat)`. Note 0 is a legal note.
- Per-channel priority on each en cycle: gate-off, then trigger, then step.
- Gate-off (`!note_on`):
  - state ← IDLE.
  - amount holds its current value.
  - active ← 0.
- Trigger, from any state:
  - state ← RUN.
  - timer ← 1.
  - note_q ← note; dir_q ← rise.
  - amount ← 0 if rise = 0, else LIMIT.
  - A trigger during RUN or HOLD restarts the sweep in the same cycle, with no idle gap.
- Step, in RUN with no trigger:
  - If timer > THRESH: timer ← 1, and amount moves one count toward its end value (+1 for fall, −1 for rise).
  - Otherwise: timer ← timer + (1 << speed). The shift is zero-extended to ACC_W, and speed is read live every cycle.
  - When the step lands amount on its end value (LIMIT for fall, 0 for rise): state ← HOLD and done pulses in that same cycle.
  - amount never passes its end value.
- HOLD: amount frozen at the end value; active = 0. Only a trigger or gate-off leaves HOLD.
- on_q ← note_on on every en cycle.
- Channels never interact; simultaneous events on different channels are all serviced in the same cycle.

## Timing
- All outputs are registered.
- Reset values (async on reset_n low):
  - amount = 0, active = 0, done = 0.
  - timer = 1, state = IDLE.
  - note_q = 0, dir_q = 0, on_q = 0.
- Reset mid-sweep aborts immediately. The first trigger after release needs a note_on rising edge, because on_q = 0.
- Trigger latency: amount and active show their start values in the cycle after the trigger cycle.
- Step period is the number of en cycles per count:
  - speed 13..15: 2 cycles.
  - speed 0: 8192 cycles.
  - In general: ceil(THRESH / 2^speed) + 1 cycles.
- en low:
  - No state changes.
  - done forced to 0.
  - Triggers are not evaluated and the gate is not sampled.
- done is high for exactly one clk cycle per completed sweep. It is never asserted for a sweep cut short by gate-off or retrigger.

## Test plan
- LIMIT = 4, ch0 fall, speed = 13, note_on rises with note 60:
  - amount = 0 the cycle after the trigger.
  - amount becomes 1, 2, 3, 4 on RUN cycles 2, 4, 6, 8.
  - done pulses on cycle 8, then HOLD with active = 0 and amount = 4 held.
- Same setup with rise = 1: amount starts at 4 and reaches 0 on RUN cycle 8, with one done pulse.
- Note change mid-sweep:
  - Mid-sweep at amount = 2, change note 60 → 62 while the gate stays high: the next cycle shows amount = 0, active = 1, and no done pulse.
  - Repeat with note unchanged plus a one-cycle note_repeat: same result.
- Gate-off at amount = 3:
  - amount stays 3 and active = 0 indefinitely.
  - Gate-on with note 0 restarts the sweep at 0.
- en toggling 1 cycle in 4 at speed 13:
  - Steps occur every 2 enabled cycles (8 clk).
  - done is exactly one clk wide.
- Multi-channel and reset:
  - Triggers in the same cycle on ch0 (speed 15) and ch3 (speed 0): ch0 increments every 2 cycles while ch3 is still 0 after 8191 cycles.
  - Asserting reset_n low mid-sweep zeroes all outputs asynchronously.
